// File: rtl/card_dealer_arb.sv
// Finite-deck card source: round-robin grants one card per request, drawn by an LFSR
// probe that walks forward past exhausted values; SHUFFLE (IDLE only) restores the deck.
module card_dealer_arb #(
  parameter int          NREQ   = 4,
  parameter int          COPIES = 4,
  parameter logic [15:0] SEED   = 16'd55332
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_shuffle,
  output logic [NREQ-1:0] o_gnt,
  output logic [3:0]      o_card,
  output logic            o_card_valid,
  output logic [5:0]      o_cards_left,
  output logic            o_deck_empty,
  output logic            o_busy
);

  localparam int          PW       = $clog2(NREQ);
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [2:0]  FULL     = 3'(COPIES);
  localparam logic [5:0]  DECK     = 6'(8 * COPIES);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_DRAW, S_DEAL} state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_lfsr;
  logic [15:0]     w_lfsr_next;
  logic [2:0]      r_cnt [8];
  logic [5:0]      r_cards_left;
  logic            r_deck_empty;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_winner;
  logic [PW-1:0]   w_winner;
  logic            w_found;
  logic            w_start;
  logic [2:0]      r_probe;
  logic            w_hit;
  logic [3:0]      r_card;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First requester after the last winner, scanning forward with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_found && i_req[rr_idx(r_rr_ptr, i)]) begin
        w_found  = 1'b1;
        w_winner = rr_idx(r_rr_ptr, i);
      end
    end
  end

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
  assign w_hit       = (r_cnt[r_probe] != 3'd0);
  assign w_start     = (r_state == S_IDLE) && !i_shuffle && w_found && !r_deck_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_gnt        = '0;
    o_card       = 4'd0;
    o_card_valid = 1'b0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (w_start) w_next = S_ARB;
      S_ARB:  w_next = S_DRAW;
      S_DRAW: if (w_hit) w_next = S_DEAL;
      S_DEAL: begin
        w_next          = S_IDLE;
        o_gnt[r_winner] = 1'b1;
        o_card          = r_card;
        o_card_valid    = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr       <= SEED_EFF;
      for (int v = 0; v < 8; v++) r_cnt[v] <= FULL;
      r_cards_left <= DECK;
      r_deck_empty <= 1'b0;
      r_rr_ptr     <= PW'(NREQ - 1);
      r_winner     <= '0;
      r_probe      <= 3'd0;
      r_card       <= 4'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        S_IDLE: begin
          if (i_shuffle) begin
            for (int v = 0; v < 8; v++) r_cnt[v] <= FULL;
            r_cards_left <= DECK;
            r_deck_empty <= 1'b0;
          end else if (w_start) begin
            r_winner <= w_winner;
          end
        end
        S_ARB: r_probe <= r_lfsr[6:4];
        // Probe index is value-1, so 3-bit wrap gives 8 -> 1.
        S_DRAW: begin
          if (w_hit) begin
            r_cnt[r_probe] <= r_cnt[r_probe] - 3'd1;
            r_cards_left   <= r_cards_left - 6'd1;
            r_deck_empty   <= (r_cards_left == 6'd1);
            r_card         <= {1'b0, r_probe} + 4'd1;
          end else begin
            r_probe <= r_probe + 3'd1;
          end
        end
        S_DEAL: r_rr_ptr <= r_winner;
        default: ;
      endcase
    end
  end

  assign o_cards_left = r_cards_left;
  assign o_deck_empty = r_deck_empty;

endmodule

// File: tb/tb_card_dealer_arb.sv
// Directed bench for card_dealer_arb: table-driven round-robin vectors plus hand-written
// sequences for latency, deck exhaustion, shuffle, mid-deal reset and repeatability.
module tb_card_dealer_arb;

  logic       clk = 1'b0;
  logic       reset, shuffle;
  logic [3:0] req, gnt, card;
  logic       card_valid, deck_empty, busy;
  logic [5:0] cards_left;

  int n_cmp = 0;
  int n_err = 0;

  card_dealer_arb dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_shuffle    (shuffle),
    .o_gnt        (gnt),
    .o_card       (card),
    .o_card_valid (card_valid),
    .o_cards_left (cards_left),
    .o_deck_empty (deck_empty),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    reset   = 1'b1;
    req     = 4'b0000;
    shuffle = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    req   = r;
  endtask

  task automatic wait_deal(input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (card_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [12];
    bit         ok;
    int         tally [9];
    int         seen, lat;
    logic [15:0] l;
    logic [3:0] e;
    logic [3:0] run1 [10];

    reset = 1'b1; req = 4'b0000; shuffle = 1'b0;

    // Reset state, first-deal latency and first card from the LFSR.
    do_reset(4'b0001);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_card", 32'(card), 0);
    check("reset_valid", 32'(card_valid), 0);
    check("reset_left", 32'(cards_left), 32);
    check("reset_empty", 32'(deck_empty), 0);
    check("reset_busy", 32'(busy), 0);
    tick();
    check("t1_valid_c1", 32'(card_valid), 0);
    tick();
    check("t1_valid_c2", 32'(card_valid), 0);
    tick();
    check("t1_valid_c3", 32'(card_valid), 1);
    check("t1_gnt", 32'(gnt), 32'(4'b0001));
    l = lstep(16'd55332);
    e = {1'b0, l[6:4]} + 4'd1;
    check("t1_card", 32'(card), 32'(e));
    check("t1_left", 32'(cards_left), 31);
    req = 4'b0000;
    tick();
    check("t1_valid_after", 32'(card_valid), 0);
    check("t1_gnt_after", 32'(gnt), 0);
    check("t1_card_after", 32'(card), 0);

    // Round-robin vectors; pointer starts at requester 3.
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1010, 4'b0010};
    tbl[6]  = '{4'b1001, 4'b1000};
    tbl[7]  = '{4'b0110, 4'b0010};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b0011, 4'b0001};
    tbl[10] = '{4'b1100, 4'b0100};
    tbl[11] = '{4'b1000, 4'b1000};
    do_reset(4'b0000);
    for (int k = 0; k < 12; k++) begin
      req = tbl[k].req;
      wait_deal(20, ok);
      check("t2_deal", 32'(ok), 1);
      check("t2_gnt", 32'(gnt), 32'(tbl[k].exp_gnt));
      check("t2_left", 32'(cards_left), 32'(31 - k));
      check("t2_card_range", 32'((card >= 4'd1) && (card <= 4'd8)), 1);
    end
    req = 4'b0000;

    // Exhaust the deck through one requester.
    do_reset(4'b0100);
    for (int v = 0; v < 9; v++) tally[v] = 0;
    for (int d = 0; d < 32; d++) begin
      wait_deal(20, ok);
      check("t3_deal", 32'(ok), 1);
      if (card >= 4'd1 && card <= 4'd8) tally[card]++;
      else tally[0]++;
    end
    for (int v = 1; v <= 8; v++) check($sformatf("t3_tally_%0d", v), 32'(tally[v]), 4);
    check("t3_bad_values", 32'(tally[0]), 0);
    check("t3_left", 32'(cards_left), 0);
    check("t3_empty", 32'(deck_empty), 1);
    seen = 0;
    repeat (50) begin
      tick();
      if (card_valid) seen++;
    end
    check("t3_no_grant_empty", 32'(seen), 0);
    check("t3_idle", 32'(busy), 0);

    // Shuffle beats REQ in the same cycle; deal follows once SHUFFLE drops.
    shuffle = 1'b1;
    req     = 4'b0001;
    tick();
    check("t4_left", 32'(cards_left), 32);
    check("t4_empty", 32'(deck_empty), 0);
    check("t4_valid", 32'(card_valid), 0);
    check("t4_busy", 32'(busy), 0);
    shuffle = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (card_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_deal", 32'(ok), 1);
    check("t4_latency", 32'(lat), 3);
    check("t4_gnt", 32'(gnt), 32'(4'b0001));
    req = 4'b0000;

    // Reset while drawing aborts the deal and restores the deck.
    do_reset(4'b0001);
    tick();
    tick();
    check("t5_busy_draw", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check("t5_valid", 32'(card_valid), 0);
    check("t5_left", 32'(cards_left), 32);
    check("t5_busy", 32'(busy), 0);
    reset = 1'b0;
    req   = 4'b1111;
    wait_deal(20, ok);
    check("t5_deal", 32'(ok), 1);
    check("t5_gnt", 32'(gnt), 32'(4'b0001));
    check("t5_left_after", 32'(cards_left), 31);
    req = 4'b0000;

    // Identical stimulus from reset yields identical card sequences.
    do_reset(4'b0001);
    for (int i = 0; i < 10; i++) begin
      wait_deal(20, ok);
      check("t6_run1_deal", 32'(ok), 1);
      run1[i] = card;
    end
    do_reset(4'b0001);
    for (int i = 0; i < 10; i++) begin
      wait_deal(20, ok);
      check("t6_run2_deal", 32'(ok), 1);
      check($sformatf("t6_card_%0d", i), 32'(card), 32'(run1[i]));
    end
    req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
